// File: rtl/inst_fetch_axi_pkg.sv
// rtl/inst_fetch_axi_pkg.sv - shared constants for the instruction-fetch stage
package inst_fetch_axi_pkg;

    localparam logic [31:0] IF_RESET_PC = 32'hBFC0_0000;
    localparam logic [31:0] ZEROWORD    = 32'h0000_0000;

    localparam logic RST_ENABLE = 1'b0;
    localparam logic STOP       = 1'b1;
    localparam logic NOT_STOP   = 1'b0;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] FETCH_ADDR  = 2'd0;
    localparam logic [1:0] FETCH_DATA  = 2'd1;
    localparam logic [1:0] FETCH_VALID = 2'd2;

    // Instruction access, secure, unprivileged.
    localparam logic [2:0] ARPROT_INST = 3'b100;

endpackage

// File: rtl/inst_fetch_axi_pc_next_sel.sv
// rtl/inst_fetch_axi_pc_next_sel.sv - next-PC priority mux: flush, then branch, then pc+4
module inst_fetch_axi_pc_next_sel #(
    parameter int ADDR_W = 32
) (
    input  logic              i_flush,
    input  logic [ADDR_W-1:0] i_new_pc,
    input  logic              i_branch_flag,
    input  logic [ADDR_W-1:0] i_branch_target,
    input  logic [ADDR_W-1:0] i_pc,
    output logic [ADDR_W-1:0] o_next_pc
);

    always_comb begin
        o_next_pc = i_pc + ADDR_W'(4);
        if (i_flush) begin
            o_next_pc = i_new_pc;
        end else if (i_branch_flag) begin
            o_next_pc = i_branch_target;
        end
    end

endmodule

// File: rtl/inst_fetch_axi.sv
// rtl/inst_fetch_axi.sv - IF stage: owns the PC and fetches one instruction per AXI-Lite read
module inst_fetch_axi
    import inst_fetch_axi_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = IF_RESET_PC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [5:0]        stall,
    input  logic              branch_flag,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              flush,
    input  logic [ADDR_W-1:0] new_pc,
    output logic [ADDR_W-1:0] m_araddr,
    output logic [2:0]        m_arprot,
    output logic              m_arvalid,
    input  logic              m_arready,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic [1:0]        m_rresp,
    input  logic              m_rvalid,
    output logic              m_rready,
    output logic [ADDR_W-1:0] if_pc,
    output logic [DATA_W-1:0] if_inst,
    output logic              if_fetch_err,
    output logic              stallreq_if
);

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_araddr;
    logic              r_arvalid;
    logic              r_discard;
    logic [ADDR_W-1:0] r_if_pc;
    logic [DATA_W-1:0] r_if_inst;
    logic              r_if_fetch_err;

    logic [ADDR_W-1:0] w_next_pc;
    logic              w_resp_err;
    logic              w_misaligned;
    logic              w_unused;

    assign w_resp_err   = (m_rresp != RESP_OKAY);
    assign w_misaligned = (r_pc[1:0] != 2'b00);
    assign w_unused     = ^stall[5:1];

    inst_fetch_axi_pc_next_sel #(
        .ADDR_W (ADDR_W)
    ) u_pc_next_sel (
        .i_flush         (flush),
        .i_new_pc        (new_pc),
        .i_branch_flag   (branch_flag),
        .i_branch_target (branch_target),
        .i_pc            (r_pc),
        .o_next_pc       (w_next_pc)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) begin
            r_state        <= FETCH_ADDR;
            r_pc           <= RESET_PC;
            r_araddr       <= RESET_PC;
            r_arvalid      <= 1'b0;
            r_discard      <= 1'b0;
            r_if_pc        <= ZEROWORD;
            r_if_inst      <= ZEROWORD;
            r_if_fetch_err <= 1'b0;
        end else begin
            case (r_state)
                FETCH_ADDR: begin
                    // An issued AR must hold address and valid until accepted, so a flush
                    // here only retargets the PC and marks the in-flight read for discard.
                    if (r_arvalid) begin
                        if (m_arready) begin
                            r_arvalid <= 1'b0;
                            r_state   <= FETCH_DATA;
                        end
                        if (flush) begin
                            r_pc      <= new_pc;
                            r_discard <= 1'b1;
                        end
                    end else if (flush) begin
                        r_pc <= new_pc;
                    end else if (w_misaligned) begin
                        r_state        <= FETCH_VALID;
                        r_if_pc        <= r_pc;
                        r_if_inst      <= ZEROWORD;
                        r_if_fetch_err <= 1'b1;
                    end else begin
                        r_arvalid <= 1'b1;
                        r_araddr  <= r_pc;
                    end
                end
                FETCH_DATA: begin
                    if (m_rvalid) begin
                        if (r_discard || flush) begin
                            r_state   <= FETCH_ADDR;
                            r_discard <= 1'b0;
                        end else begin
                            r_state        <= FETCH_VALID;
                            r_if_pc        <= r_pc;
                            r_if_inst      <= w_resp_err ? ZEROWORD : m_rdata;
                            r_if_fetch_err <= w_resp_err;
                        end
                        if (flush) begin
                            r_pc <= new_pc;
                        end
                    end else if (flush) begin
                        r_pc      <= new_pc;
                        r_discard <= 1'b1;
                    end
                end
                FETCH_VALID: begin
                    if (flush || (stall[0] == NOT_STOP)) begin
                        r_pc    <= w_next_pc;
                        r_state <= FETCH_ADDR;
                    end
                end
                default: begin
                    r_state <= FETCH_ADDR;
                end
            endcase
        end
    end

    assign m_araddr     = r_araddr;
    assign m_arprot     = ARPROT_INST;
    assign m_arvalid    = r_arvalid;
    assign m_rready     = (r_state == FETCH_DATA);
    assign if_pc        = r_if_pc;
    assign if_inst      = r_if_inst;
    assign if_fetch_err = r_if_fetch_err;
    assign stallreq_if  = (r_state != FETCH_VALID);

endmodule

// File: tb/tb_inst_fetch_axi.sv
// tb/tb_inst_fetch_axi.sv - directed self-checking bench for inst_fetch_axi
module tb_inst_fetch_axi;
    import inst_fetch_axi_pkg::*;

    logic        clk;
    logic        rst;
    logic [5:0]  stall;
    logic        branch_flag;
    logic [31:0] branch_target;
    logic        flush;
    logic [31:0] new_pc;
    logic [31:0] m_araddr;
    logic [2:0]  m_arprot;
    logic        m_arvalid;
    logic        m_arready;
    logic [31:0] m_rdata;
    logic [1:0]  m_rresp;
    logic        m_rvalid;
    logic        m_rready;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_fetch_err;
    logic        stallreq_if;

    int errors = 0;
    int checks = 0;

    // Slave model controls
    logic        ar_en;
    int          rd_delay;
    logic [1:0]  resp_cfg;
    logic        pend;
    int          cnt;
    logic [31:0] p_addr;
    int          ar_count;

    inst_fetch_axi dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .branch_flag   (branch_flag),
        .branch_target (branch_target),
        .flush         (flush),
        .new_pc        (new_pc),
        .m_araddr      (m_araddr),
        .m_arprot      (m_arprot),
        .m_arvalid     (m_arvalid),
        .m_arready     (m_arready),
        .m_rdata       (m_rdata),
        .m_rresp       (m_rresp),
        .m_rvalid      (m_rvalid),
        .m_rready      (m_rready),
        .if_pc         (if_pc),
        .if_inst       (if_inst),
        .if_fetch_err  (if_fetch_err),
        .stallreq_if   (stallreq_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] fd(input logic [31:0] a);
        return (a == 32'hBFC0_0000) ? 32'h2408_0001 : (a ^ 32'hA5A5_5A5A);
    endfunction

    assign m_arready = ar_en;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_rvalid <= 1'b0;
            m_rdata  <= 32'h0;
            m_rresp  <= 2'b00;
            pend     <= 1'b0;
            cnt      <= 0;
            p_addr   <= 32'h0;
            ar_count <= 0;
        end else begin
            if (m_rvalid && m_rready) m_rvalid <= 1'b0;
            if (m_arvalid && m_arready) begin
                ar_count <= ar_count + 1;
                if (rd_delay == 0) begin
                    m_rvalid <= 1'b1;
                    m_rdata  <= fd(m_araddr);
                    m_rresp  <= resp_cfg;
                end else begin
                    pend   <= 1'b1;
                    cnt    <= rd_delay;
                    p_addr <= m_araddr;
                end
            end else if (pend) begin
                if (cnt <= 1) begin
                    m_rvalid <= 1'b1;
                    m_rdata  <= fd(p_addr);
                    m_rresp  <= resp_cfg;
                    pend     <= 1'b0;
                end else begin
                    cnt <= cnt - 1;
                end
            end
        end
    end

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (stallreq_if === 1'b0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_ar(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (m_arvalid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic advance();
        stall[0] = 1'b0;
        @(negedge clk);
        stall[0] = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0; stall = 6'h01; branch_flag = 1'b0; branch_target = 32'h0;
        flush = 1'b0; new_pc = 32'h0; ar_en = 1'b1; rd_delay = 0; resp_cfg = RESP_OKAY;
        repeat (2) @(negedge clk);
        checks++; if (m_arvalid !== 1'b0) begin errors++; $display("FAIL rst_arvalid got=%b exp=0", m_arvalid); end
        checks++; if (m_rready !== 1'b0) begin errors++; $display("FAIL rst_rready got=%b exp=0", m_rready); end
        checks++; if (if_pc !== 32'h0) begin errors++; $display("FAIL rst_if_pc got=%h exp=0", if_pc); end
        checks++; if (if_inst !== 32'h0) begin errors++; $display("FAIL rst_if_inst got=%h exp=0", if_inst); end
        checks++; if (if_fetch_err !== 1'b0) begin errors++; $display("FAIL rst_err got=%b exp=0", if_fetch_err); end
        checks++; if (stallreq_if !== 1'b1) begin errors++; $display("FAIL rst_stallreq got=%b exp=1", stallreq_if); end
        checks++; if (m_arprot !== 3'b100) begin errors++; $display("FAIL arprot got=%b exp=100", m_arprot); end
    endtask

    task automatic test_first_fetch();
        bit ok;
        rst = 1'b1;
        @(negedge clk);
        checks++; if (m_arvalid !== 1'b1 || m_araddr !== 32'hBFC0_0000) begin errors++; $display("FAIL t1_ar got=%b/%h exp=1/bfc00000", m_arvalid, m_araddr); end
        @(negedge clk);
        checks++; if (stallreq_if !== 1'b1 || m_rready !== 1'b1) begin errors++; $display("FAIL t1_data got=%b/%b exp=1/1", stallreq_if, m_rready); end
        @(negedge clk);
        checks++; if (stallreq_if !== 1'b0) begin errors++; $display("FAIL t1_valid_lat got=%b exp=0", stallreq_if); end
        checks++; if (if_inst !== 32'h2408_0001) begin errors++; $display("FAIL t1_inst got=%h exp=24080001", if_inst); end
        checks++; if (if_pc !== 32'hBFC0_0000 || if_fetch_err !== 1'b0) begin errors++; $display("FAIL t1_pc got=%h/%b exp=bfc00000/0", if_pc, if_fetch_err); end
        advance();
        @(negedge clk);
        checks++; if (m_arvalid !== 1'b1 || m_araddr !== 32'hBFC0_0004) begin errors++; $display("FAIL t1_next_ar got=%b/%h exp=1/bfc00004", m_arvalid, m_araddr); end
        wait_valid(ok);
        checks++; if (!ok || if_pc !== 32'hBFC0_0004 || if_inst !== fd(32'hBFC0_0004)) begin errors++; $display("FAIL t1_second got=%b/%h/%h exp=1/bfc00004/%h", ok, if_pc, if_inst, fd(32'hBFC0_0004)); end
    endtask

    task automatic test_stall_hold();
        bit ok;
        int n0;
        logic [31:0] pc0, inst0;
        n0 = ar_count; pc0 = if_pc; inst0 = if_inst;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++; if (if_pc !== pc0 || if_inst !== inst0 || stallreq_if !== 1'b0 || m_arvalid !== 1'b0) begin
                errors++; $display("FAIL t2_hold%0d got=%h/%h/%b/%b exp=%h/%h/0/0", i, if_pc, if_inst, stallreq_if, m_arvalid, pc0, inst0);
            end
        end
        checks++; if (ar_count !== n0) begin errors++; $display("FAIL t2_no_ar got=%0d exp=%0d", ar_count, n0); end
        advance();
        wait_ar(ok);
        checks++; if (!ok || m_araddr !== 32'hBFC0_0008) begin errors++; $display("FAIL t2_adv got=%b/%h exp=1/bfc00008", ok, m_araddr); end
        wait_valid(ok);
        checks++; if (!ok || if_pc !== 32'hBFC0_0008) begin errors++; $display("FAIL t2_valid got=%b/%h exp=1/bfc00008", ok, if_pc); end
    endtask

    task automatic test_branch_flush();
        bit ok;
        branch_flag = 1'b1; branch_target = 32'h8000_0100;
        advance();
        branch_flag = 1'b0;
        wait_ar(ok);
        checks++; if (!ok || m_araddr !== 32'h8000_0100) begin errors++; $display("FAIL t3_branch got=%b/%h exp=1/80000100", ok, m_araddr); end
        wait_valid(ok);
        checks++; if (!ok || if_pc !== 32'h8000_0100 || if_inst !== fd(32'h8000_0100)) begin errors++; $display("FAIL t3_br_valid got=%b/%h/%h", ok, if_pc, if_inst); end
        branch_flag = 1'b1; flush = 1'b1; new_pc = 32'hBFC0_0380;
        advance();
        branch_flag = 1'b0; flush = 1'b0;
        wait_ar(ok);
        checks++; if (!ok || m_araddr !== 32'hBFC0_0380) begin errors++; $display("FAIL t3_flush_prio got=%b/%h exp=1/bfc00380", ok, m_araddr); end
        wait_valid(ok);
        checks++; if (!ok || if_pc !== 32'hBFC0_0380) begin errors++; $display("FAIL t3_fl_valid got=%b/%h exp=1/bfc00380", ok, if_pc); end
    endtask

    task automatic test_flush_in_data();
        bit ok;
        int n0;
        rd_delay = 4;
        n0 = ar_count;
        advance();
        wait_ar(ok);
        checks++; if (!ok || m_araddr !== 32'hBFC0_0384) begin errors++; $display("FAIL t4_ar got=%b/%h exp=1/bfc00384", ok, m_araddr); end
        @(negedge clk);
        checks++; if (m_rready !== 1'b1) begin errors++; $display("FAIL t4_in_data got=%b exp=1", m_rready); end
        flush = 1'b1; new_pc = 32'h8000_0200;
        @(negedge clk);
        flush = 1'b0;
        rd_delay = 0;
        wait_ar(ok);
        checks++; if (!ok || m_araddr !== 32'h8000_0200) begin errors++; $display("FAIL t4_redirect got=%b/%h exp=1/80000200", ok, m_araddr); end
        checks++; if (if_inst !== fd(32'hBFC0_0380) || if_pc !== 32'hBFC0_0380 || stallreq_if !== 1'b1) begin
            errors++; $display("FAIL t4_dropped got=%h/%h/%b exp=%h/bfc00380/1", if_inst, if_pc, stallreq_if, fd(32'hBFC0_0380));
        end
        wait_valid(ok);
        checks++; if (!ok || if_pc !== 32'h8000_0200 || if_inst !== fd(32'h8000_0200)) begin errors++; $display("FAIL t4_valid got=%b/%h/%h", ok, if_pc, if_inst); end
        checks++; if (ar_count !== n0 + 2) begin errors++; $display("FAIL t4_ar_count got=%0d exp=%0d", ar_count, n0 + 2); end
    endtask

    task automatic test_errors();
        bit ok;
        int n0;
        resp_cfg = RESP_SLVERR;
        advance();
        wait_valid(ok);
        resp_cfg = RESP_OKAY;
        checks++; if (!ok || if_pc !== 32'h8000_0204) begin errors++; $display("FAIL t5_slverr_pc got=%b/%h exp=1/80000204", ok, if_pc); end
        checks++; if (if_inst !== 32'h0 || if_fetch_err !== 1'b1) begin errors++; $display("FAIL t5_slverr got=%h/%b exp=0/1", if_inst, if_fetch_err); end
        n0 = ar_count;
        flush = 1'b1; new_pc = 32'h8000_0002;
        @(negedge clk);
        flush = 1'b0;
        wait_valid(ok);
        checks++; if (!ok || if_pc !== 32'h8000_0002 || if_inst !== 32'h0 || if_fetch_err !== 1'b1) begin
            errors++; $display("FAIL t5_misalign got=%b/%h/%h/%b exp=1/80000002/0/1", ok, if_pc, if_inst, if_fetch_err);
        end
        checks++; if (ar_count !== n0) begin errors++; $display("FAIL t5_no_ar got=%0d exp=%0d", ar_count, n0); end
    endtask

    task automatic test_ar_stall_flush();
        bit ok;
        int n0;
        ar_en = 1'b0;
        n0 = ar_count;
        flush = 1'b1; new_pc = 32'h8000_1000;
        @(negedge clk);
        flush = 1'b0;
        wait_ar(ok);
        checks++; if (!ok || m_araddr !== 32'h8000_1000) begin errors++; $display("FAIL t6_ar got=%b/%h exp=1/80001000", ok, m_araddr); end
        flush = 1'b1; new_pc = 32'h8000_2000;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            flush = 1'b0;
            checks++; if (m_arvalid !== 1'b1 || m_araddr !== 32'h8000_1000) begin
                errors++; $display("FAIL t6_stable%0d got=%b/%h exp=1/80001000", i, m_arvalid, m_araddr);
            end
        end
        ar_en = 1'b1;
        @(negedge clk);
        wait_ar(ok);
        checks++; if (!ok || m_araddr !== 32'h8000_2000) begin errors++; $display("FAIL t6_reissue got=%b/%h exp=1/80002000", ok, m_araddr); end
        wait_valid(ok);
        checks++; if (!ok || if_pc !== 32'h8000_2000 || if_inst !== fd(32'h8000_2000) || if_fetch_err !== 1'b0) begin
            errors++; $display("FAIL t6_valid got=%b/%h/%h/%b", ok, if_pc, if_inst, if_fetch_err);
        end
        checks++; if (ar_count !== n0 + 2) begin errors++; $display("FAIL t6_ar_count got=%0d exp=%0d", ar_count, n0 + 2); end
    endtask

    initial begin
        test_reset();
        test_first_fetch();
        test_stall_hold();
        test_branch_flush();
        test_flush_in_data();
        test_errors();
        test_ar_stall_flush();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
